// File: rtl/motor_pkg.sv
// Shared types and datapath widths for the speed regulator.
package motor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        PROD,
        SUM,
        LIMIT
    } spc_state_t;

    localparam int ERR_W = 17;
    localparam int INT_W = 24;
    localparam int SUM_W = 34;
    localparam int PSV_W = 7;

endpackage

// File: rtl/sat_slew.sv
// Saturates the PI output to 0..PSV_MAX, then limits the step from the current psv to SLEW_MAX.
module sat_slew
    import motor_pkg::*;
#(
    parameter int PSV_MAX  = 100,
    parameter int SLEW_MAX = 10
) (
    input  logic signed [SUM_W-1:0] u,
    input  logic        [PSV_W-1:0] psv_cur,
    output logic        [PSV_W-1:0] psv_new,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    localparam logic signed [SUM_W-1:0] PSV_MAX_S = SUM_W'(PSV_MAX);
    localparam logic        [PSV_W-1:0] PSV_MAX_L = PSV_W'(PSV_MAX);
    localparam logic        [PSV_W-1:0] SLEW_L    = PSV_W'(SLEW_MAX);

    logic [PSV_W-1:0] sat_val;
    logic [PSV_W-1:0] diff;
    logic [PSV_W-1:0] step;

    always_comb begin
        sat_hi = (u > PSV_MAX_S);
        sat_lo = u[SUM_W-1];

        if (sat_lo) begin
            sat_val = '0;
        end else if (sat_hi) begin
            sat_val = PSV_MAX_L;
        end else begin
            sat_val = u[PSV_W-1:0];
        end

        if (sat_val >= psv_cur) begin
            diff    = sat_val - psv_cur;
            step    = (diff > SLEW_L) ? SLEW_L : diff;
            psv_new = psv_cur + step;
        end else begin
            diff    = psv_cur - sat_val;
            step    = (diff > SLEW_L) ? SLEW_L : diff;
            psv_new = psv_cur - step;
        end
    end

endmodule

// File: rtl/speed_pi_ctrl.sv
// Sampled PI speed regulator driving the motor top's psv/ste inputs.
// Optional stall trip is built when SPEED_PI_STALL_DETECT_EN is defined.
module speed_pi_ctrl
    import motor_pkg::*;
#(
    parameter int KP         = 16,
    parameter int KI         = 2,
    parameter int GAIN_SHIFT = 4,
    parameter int PSV_MAX    = 100,
    parameter int SLEW_MAX   = 10,
    parameter int INT_LIM    = 65535
`ifdef SPEED_PI_STALL_DETECT_EN
    ,
    parameter int STALL_PSV     = 30,
    parameter int STALL_SAMPLES = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_stb,
    input  logic [15:0] target,
    input  logic [15:0] edge_l,
    input  logic [15:0] edge_r,
    input  logic [7:0]  ste_in,
    input  logic        brk,
    output logic [6:0]  psv,
    output logic [7:0]  ste,
    output logic        upd,
    output logic        busy,
    output logic        stall
);

    localparam logic signed [INT_W-1:0] INT_HI = INT_W'(INT_LIM);
    localparam logic signed [INT_W-1:0] INT_LO = -INT_HI;
    localparam logic signed [SUM_W-1:0] KP_S   = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0] KI_S   = SUM_W'(KI);

`ifdef SPEED_PI_STALL_DETECT_EN
    localparam int                 CNT_W       = $clog2(STALL_SAMPLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(STALL_SAMPLES);
    localparam logic [PSV_W-1:0]   STALL_PSV_L = PSV_W'(STALL_PSV);
`endif

    spc_state_t state_q, state_d;

    logic [15:0]             target_q, target_d;
    logic [15:0]             edge_l_q, edge_l_d;
    logic [15:0]             edge_r_q, edge_r_d;
    logic [7:0]              ste_cap_q, ste_cap_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [INT_W-1:0] integ_next_q, integ_next_d;
    logic                    meas_zero_q, meas_zero_d;
    logic signed [SUM_W-1:0] p_q, p_d;
    logic signed [SUM_W-1:0] i_q, i_d;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic [PSV_W-1:0]        psv_q, psv_d;
    logic [7:0]              ste_q, ste_d;
    logic                    upd_q, upd_d;
    logic                    busy_q, busy_d;

    // Datapath terms, each consumed by the FSM in the state that needs it
    logic [16:0]             sum17;
    logic [16:0]             meas17;
    logic signed [ERR_W-1:0] err_c;
    logic signed [INT_W-1:0] err_int;
    logic signed [INT_W-1:0] integ_sum;
    logic signed [INT_W-1:0] integ_clamp;
    logic signed [SUM_W-1:0] err_s34;
    logic signed [SUM_W-1:0] int_s34;
    logic signed [SUM_W-1:0] pi_sum;
    logic signed [SUM_W-1:0] u_c;
    logic                    err_pos;
    logic                    err_neg;

    logic [PSV_W-1:0]        psv_new;
    logic                    sat_hi;
    logic                    sat_lo;

    always_comb begin
        sum17     = {1'b0, edge_l_q} + {1'b0, edge_r_q};
        meas17    = sum17 >> 1;
        err_c     = $signed({1'b0, target_q}) - $signed(meas17);
        err_int   = {{(INT_W-ERR_W){err_c[ERR_W-1]}}, err_c};
        integ_sum = integ_q + err_int;
        if (integ_sum > INT_HI) begin
            integ_clamp = INT_HI;
        end else if (integ_sum < INT_LO) begin
            integ_clamp = INT_LO;
        end else begin
            integ_clamp = integ_sum;
        end
        err_s34 = {{(SUM_W-ERR_W){err_q[ERR_W-1]}}, err_q};
        int_s34 = {{(SUM_W-INT_W){integ_next_q[INT_W-1]}}, integ_next_q};
        pi_sum  = p_q + i_q;
        u_c     = pi_sum >>> GAIN_SHIFT;
        err_neg = err_q[ERR_W-1];
        err_pos = !err_q[ERR_W-1] && (err_q != '0);
    end

    sat_slew #(
        .PSV_MAX  (PSV_MAX),
        .SLEW_MAX (SLEW_MAX)
    ) u_sat_slew (
        .u       (u_c),
        .psv_cur (psv_q),
        .psv_new (psv_new),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo)
    );

`ifdef SPEED_PI_STALL_DETECT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_q, stall_d;
`endif

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        edge_l_d     = edge_l_q;
        edge_r_d     = edge_r_q;
        ste_cap_d    = ste_cap_q;
        err_d        = err_q;
        integ_next_d = integ_next_q;
        meas_zero_d  = meas_zero_q;
        p_d          = p_q;
        i_d          = i_q;
        integ_d      = integ_q;
        psv_d        = psv_q;
        ste_d        = ste_q;
        upd_d        = 1'b0;
`ifdef SPEED_PI_STALL_DETECT_EN
        stall_cnt_d  = stall_cnt_q;
        stall_d      = stall_q;
`endif

        case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    target_d  = target;
                    edge_l_d  = edge_l;
                    edge_r_d  = edge_r;
                    ste_cap_d = ste_in;
                    state_d   = ERR;
                end
            end
            ERR: begin
                err_d        = err_c;
                integ_next_d = integ_clamp;
                meas_zero_d  = (meas17 == '0);
                state_d      = PROD;
            end
            PROD: begin
                p_d     = err_s34 * KP_S;
                i_d     = int_s34 * KI_S;
                state_d = SUM;
            end
            SUM: begin
                // Commit here so psv, ste and upd are all presented during LIMIT
                psv_d   = psv_new;
                ste_d   = ste_cap_q;
                integ_d = ((sat_hi && err_pos) || (sat_lo && err_neg)) ? integ_q : integ_next_q;
                upd_d   = 1'b1;
`ifdef SPEED_PI_STALL_DETECT_EN
                if ((psv_new >= STALL_PSV_L) && meas_zero_q) begin
                    stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
                end else begin
                    stall_cnt_d = '0;
                end
                if (stall_cnt_d == CNT_MAX) begin
                    stall_d = 1'b1;
                end
                if (stall_d) begin
                    psv_d   = '0;
                    integ_d = '0;
                end
`endif
                state_d = LIMIT;
            end
            LIMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (brk) begin
            psv_d   = '0;
            integ_d = '0;
            upd_d   = 1'b0;
            state_d = IDLE;
`ifdef SPEED_PI_STALL_DETECT_EN
            stall_d     = 1'b0;
            stall_cnt_d = '0;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            edge_l_q     <= '0;
            edge_r_q     <= '0;
            ste_cap_q    <= '0;
            err_q        <= '0;
            integ_next_q <= '0;
            meas_zero_q  <= 1'b0;
            p_q          <= '0;
            i_q          <= '0;
            integ_q      <= '0;
            psv_q        <= '0;
            ste_q        <= '0;
            upd_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SPEED_PI_STALL_DETECT_EN
            stall_cnt_q  <= '0;
            stall_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            edge_l_q     <= edge_l_d;
            edge_r_q     <= edge_r_d;
            ste_cap_q    <= ste_cap_d;
            err_q        <= err_d;
            integ_next_q <= integ_next_d;
            meas_zero_q  <= meas_zero_d;
            p_q          <= p_d;
            i_q          <= i_d;
            integ_q      <= integ_d;
            psv_q        <= psv_d;
            ste_q        <= ste_d;
            upd_q        <= upd_d;
            busy_q       <= busy_d;
`ifdef SPEED_PI_STALL_DETECT_EN
            stall_cnt_q  <= stall_cnt_d;
            stall_q      <= stall_d;
`endif
        end
    end

    assign psv  = psv_q;
    assign ste  = ste_q;
    assign upd  = upd_q;
    assign busy = busy_q;
`ifdef SPEED_PI_STALL_DETECT_EN
    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

endmodule
